// File: rtl/sc_io_pkg.sv
// sc_io_pkg: register offsets, 7-segment pattern table and debounce counter width shared by the I/O port
package sc_io_pkg;
  localparam int DEB_CNT_W = 16;
  localparam logic [2:0] OFF_SW     = 3'd0;
  localparam logic [2:0] OFF_KEYLVL = 3'd1;
  localparam logic [2:0] OFF_KEYEVT = 3'd2;
  localparam logic [2:0] OFF_LED    = 3'd3;
  localparam logic [2:0] OFF_HEX    = 3'd4;
  localparam logic [15:0][6:0] SEG7 = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/io_debounce.sv
// io_debounce: 2-FF sync + stability counter for one active-low key; clock/reset in, raw_n in, level/rise out
module io_debounce
  import sc_io_pkg::*;
#(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_n,
  output logic level,
  output logic rise
);
  localparam logic [DEB_CNT_W-1:0] CNT_MAX = DEB_CNT_W'(DEB_CYCLES - 1);
  logic [1:0] sync_q;
  logic deb_q, deb_d, ks;
  logic [DEB_CNT_W-1:0] cnt_q, cnt_d;
  assign ks = sync_q[1];
  always_comb begin
    deb_d = (ks != deb_q && cnt_q == CNT_MAX) ? ks : deb_q;
    cnt_d = (ks == deb_q || cnt_q == CNT_MAX) ? '0 : cnt_q + DEB_CNT_W'(1);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], ~raw_n};
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end
  assign level = deb_q;
  assign rise  = ~deb_q & deb_d;
endmodule

// File: rtl/sc_io_port.sv
// sc_io_port: CPU memory-mapped I/O (addr/wdata/wmem in, io_sel/rdata out) serving sw, key_n, led and hex0..hex5
module sc_io_port
  import sc_io_pkg::*;
#(
  parameter logic [31:0] IO_BASE    = 32'h0000_0080,
  parameter int          NKEY       = 4,
  parameter int          NSW        = 10,
  parameter int          NLED       = 10,
  parameter int          DEB_CYCLES = 50000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  input  logic            wmem,
  output logic            io_sel,
  output logic [31:0]     rdata,
  input  logic [NKEY-1:0] key_n,
  input  logic [NSW-1:0]  sw,
  output logic [NLED-1:0] led,
  output logic [6:0]      hex0,
  output logic [6:0]      hex1,
  output logic [6:0]      hex2,
  output logic [6:0]      hex3,
  output logic [6:0]      hex4,
  output logic [6:0]      hex5
);
  logic [2:0] off;
  logic we, unused_ok;
  logic [NSW-1:0] sw_meta_q, sw_sync_q;
  logic [NKEY-1:0] key_deb, key_rise, key_evt_q, key_evt_d, clr;
  logic [NLED-1:0] led_q, led_d;
  logic [23:0] hex_q, hex_d;
  assign io_sel    = addr[31:5] == IO_BASE[31:5];
  assign off       = addr[4:2];
  assign we        = wmem & io_sel;
  assign unused_ok = ^{addr[1:0], wdata};
  genvar i;
  generate
    for (i = 0; i < NKEY; i++) begin : g_key
      io_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clock(clock),
        .reset(reset),
        .raw_n(key_n[i]),
        .level(key_deb[i]),
        .rise (key_rise[i])
      );
    end
  endgenerate
  always_comb begin
    clr       = (we && off == OFF_KEYEVT) ? wdata[NKEY-1:0] : '0;
    key_evt_d = (key_evt_q & ~clr) | key_rise;
    led_d     = (we && off == OFF_LED) ? wdata[NLED-1:0] : led_q;
    hex_d     = (we && off == OFF_HEX) ? wdata[23:0] : hex_q;
    rdata     = !io_sel              ? '0
              : off == OFF_SW        ? 32'(sw_sync_q)
              : off == OFF_KEYLVL    ? 32'(key_deb)
              : off == OFF_KEYEVT    ? 32'(key_evt_q)
              : off == OFF_LED       ? 32'(led_q)
              : off == OFF_HEX       ? {8'h0, hex_q}
              : '0;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      key_evt_q <= '0;
      led_q     <= '0;
      hex_q     <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      key_evt_q <= key_evt_d;
      led_q     <= led_d;
      hex_q     <= hex_d;
    end
  end
  assign led  = led_q;
  assign hex0 = SEG7[hex_q[3:0]];
  assign hex1 = SEG7[hex_q[7:4]];
  assign hex2 = SEG7[hex_q[11:8]];
  assign hex3 = SEG7[hex_q[15:12]];
  assign hex4 = SEG7[hex_q[19:16]];
  assign hex5 = SEG7[hex_q[23:20]];
endmodule

// File: tb/tb_sc_io_port.sv
// tb_sc_io_port: randomized scoreboard bench for sc_io_port against a window-based behavioural model
module tb_sc_io_port;
  localparam int D = 8;
  logic clock = 0, reset = 0, wmem = 0, io_sel;
  logic [31:0] addr = 0, wdata = 0, rdata;
  logic [3:0] key_n = 4'hF;
  logic [9:0] sw = 0, led;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  int errors = 0, checks = 0;
  always #5 clock = ~clock;
  sc_io_port #(.DEB_CYCLES(D)) dut (
    .clock(clock), .reset(reset), .addr(addr), .wdata(wdata), .wmem(wmem),
    .io_sel(io_sel), .rdata(rdata), .key_n(key_n), .sw(sw), .led(led),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
  );
  typedef struct {int kind; logic [31:0] exp; string nm;} item_t;
  item_t sbq[$];
  logic [9:0] m_led;
  logic [23:0] m_hex;
  logic [3:0] m_deb, m_evt;
  bit khist[4][$];
  logic [9:0] swh[$];
  function automatic bit win(input logic [31:0] a);
    return a >= 32'h80 && a < 32'hA0;
  endfunction
  function automatic int offs(input logic [31:0] a);
    return int'((a - 32'h80) >> 2);
  endfunction
  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction
  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!win(a)) return 0;
    case (offs(a))
      0: return swh.size() < 2 ? 32'h0 : {22'h0, swh[swh.size()-2]};
      1: return {28'h0, m_deb};
      2: return {28'h0, m_evt};
      3: return {22'h0, m_led};
      4: return {8'h0, m_hex};
      default: return 0;
    endcase
  endfunction
  always @(posedge clock or posedge reset) begin : model
    logic [3:0] clr, deb_n, evt_n;
    int n;
    bit flip;
    if (reset) begin
      m_led <= 0;
      m_hex <= 0;
      m_deb <= 0;
      m_evt <= 0;
      swh.delete();
      for (int k = 0; k < 4; k++) begin
        khist[k].delete();
        khist[k].push_back(1'b0);
        khist[k].push_back(1'b0);
      end
    end else begin
      clr = 0;
      if (wmem && win(addr)) begin
        if (offs(addr) == 2) clr = wdata[3:0];
        if (offs(addr) == 3) m_led <= wdata[9:0];
        if (offs(addr) == 4) m_hex <= wdata[23:0];
      end
      deb_n = m_deb;
      evt_n = m_evt & ~clr;
      for (int k = 0; k < 4; k++) begin
        khist[k].push_back(!key_n[k]);
        n = khist[k].size();
        if (n >= D + 2) begin
          flip = 1;
          for (int j = 0; j < D; j++) if (khist[k][n-3-j] == deb_n[k]) flip = 0;
          if (flip) begin
            deb_n[k] = !deb_n[k];
            if (deb_n[k]) evt_n[k] = 1'b1;
          end
        end
        if (n > 2 * D) void'(khist[k].pop_front());
      end
      m_deb <= deb_n;
      m_evt <= evt_n;
      swh.push_back(sw);
      if (swh.size() > 3) void'(swh.pop_front());
    end
  end
  function automatic logic [31:0] actual(input int kind);
    case (kind)
      0: return rdata;
      1: return {31'h0, io_sel};
      2: return {22'h0, led};
      3: return {25'h0, hex0};
      4: return {25'h0, hex1};
      5: return {25'h0, hex2};
      6: return {25'h0, hex3};
      7: return {25'h0, hex4};
      default: return {25'h0, hex5};
    endcase
  endfunction
  always @(negedge clock) begin : monitor
    item_t it;
    logic [31:0] act;
    #2;
    while (sbq.size() > 0) begin
      it = sbq.pop_front();
      act = actual(it.kind);
      checks++;
      if (act !== it.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h at %0t", it.nm, act, it.exp, $time);
      end
    end
  end
  task automatic push_exp(input int kind, input logic [31:0] e, input string nm);
    item_t it;
    it.kind = kind;
    it.exp = e;
    it.nm = nm;
    sbq.push_back(it);
  endtask
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w, input bit chk);
    @(negedge clock);
    addr = a;
    wdata = d;
    wmem = w;
    if (chk) begin
      push_exp(0, m_read(a), $sformatf("rdata@%h", a));
      push_exp(1, {31'h0, win(a)}, $sformatf("io_sel@%h", a));
    end
  endtask
  task automatic chk_outs();
    push_exp(2, {22'h0, m_led}, "led");
    for (int k = 0; k < 6; k++) push_exp(3 + k, {25'h0, seg(m_hex[4*k+:4])}, $sformatf("hex%0d", k));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] a;
    int r, k;
    #1 reset = 1;
    repeat (3) @(negedge clock);
    reset = 0;
    for (int o = 0; o < 8; o++) step(32'h80 + 4 * o, 0, 0, 1);
    chk_outs();
    step(32'h8C, 32'h3FF, 1, 0);
    step(32'h8C, 0, 0, 1);
    chk_outs();
    key_n[0] = 0;
    repeat (5) step(32'h84, 0, 0, 1);
    @(posedge clock);
    #2 reset = 1;
    step(32'h84, 0, 0, 1);
    step(32'h88, 0, 0, 1);
    chk_outs();
    @(negedge clock);
    reset = 0;
    key_n[0] = 1;
    repeat (15) step(32'h84, 0, 0, 1);
    chk_outs();
    key_n[1] = 0;
    repeat (12) step(32'h84, 0, 0, 1);
    step(32'h88, 0, 0, 1);
    key_n[2] = 0;
    repeat (7) step(32'h84, 0, 0, 1);
    key_n[2] = 1;
    repeat (12) step(32'h88, 0, 0, 1);
    key_n[0] = 0;
    repeat (12) step(32'h88, 0, 0, 1);
    step(32'h88, 32'h1, 1, 1);
    step(32'h88, 0, 0, 1);
    key_n[2] = 0;
    for (int i = 0; i < 12; i++) step(32'h88, 32'h4, i == 8, 1);
    step(32'h84, 0, 0, 1);
    step(32'h90, 32'hFF12_3456, 1, 0);
    step(32'h90, 0, 0, 1);
    chk_outs();
    step(32'h8C, 32'hFFFF_FFFF, 1, 0);
    step(32'h8D, 0, 0, 1);
    chk_outs();
    step(32'h9F, 0, 0, 1);
    step(32'h7C, 32'h0, 1, 1);
    step(32'hA0, 32'h0, 1, 1);
    step(32'h1000_008C, 32'h0, 1, 1);
    step(32'h94, 32'hFFFF_FFFF, 1, 1);
    step(32'h98, 32'hFFFF_FFFF, 1, 1);
    step(32'h9C, 32'hFFFF_FFFF, 1, 1);
    step(32'h8C, 0, 0, 1);
    step(32'h90, 0, 0, 1);
    chk_outs();
    for (int o = 5; o < 8; o++) step(32'h80 + 4 * o, 0, 0, 1);
    sw = 10'h2A5;
    repeat (3) step(32'h80, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      a = r < 7 ? 32'h80 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3)
        : r == 7 ? 32'h7C : r == 8 ? 32'hA0 : $urandom;
      step(a, $urandom, $urandom_range(0, 3) == 0, 1);
      if (i % 8 == 0) chk_outs();
      if ($urandom_range(0, 14) == 0) begin
        k = $urandom_range(0, 3);
        key_n[k] = ~key_n[k];
      end
      if ($urandom_range(0, 19) == 0) sw = 10'($urandom);
    end
    repeat (2) @(negedge clock);
    #5;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
